innings_controller: RTL and testbench
=====================================

// Module: innings_controller
// PURPOSE
//  Match sequencer on the consuming side of the scoring datapath. Reads the packed
//  team1Data/team2Data words {runs[11:4], wickets[3:0]} from the score block.
//  Counts legal deliveries and closes innings 1. Drives teamSwitch, target and
//  gameOver back into the score block, and resolves the winner.
//  Sits between the play/LFSR front end and the score/display path.
// PARAMETERS
//  OVERS           20  overs per innings (1..31)
//  BALLS_PER_OVER  6   legal deliveries per over (1..7)
//  MAX_WICKETS     10  wickets that end an innings (1..15)
// PORTS
//  clk_fpga      in   1   system clock; all state on rising edge
//  reset         in   1   synchronous, active-high
//  play          in   1   one-cycle delivery pulse (same pulse fed to score block)
//  lfsr_out      in   4   delivery code for this pulse; 13/14 = wide/no-ball
//  team1Data     in   12  {runs,wickets} of team 1 from score block
//  team2Data     in   12  {runs,wickets} of team 2 from score block
//  teamSwitch    out  1   0 = team 1 batting, 1 = team 2 batting
//  gameOver      out  1   high in DONE; freezes score block
//  overs         out  5   completed overs in current innings
//  ballsInOver   out  3   legal balls in current over, 0..BALLS_PER_OVER-1
//  target        out  9   team1 runs + 1, valid once teamSwitch=1; else 0
//  winner        out  2   00 none, 01 team 1, 10 team 2, 11 tie
//  matchState    out  2   00 INN1, 01 INN2, 10 DONE (debug/display)
// BEHAVIOUR
//  Reset (sync): state=INN1, teamSwitch=0, gameOver=0, overs=0, ballsInOver=0,
//   target=0, winner=00. Reset mid-match aborts in the same edge; nothing else wins.
//  Ball count: on play in INN1/INN2 with lfsr_out not in {13,14}, ballsInOver++.
//   When ballsInOver reaches BALLS_PER_OVER-1 and increments, it wraps to 0 and
//   overs++. Wide/no-ball leaves both counters unchanged. The wicket code (15) is a
//   legal ball.
//  Counters and teamData both update on the play edge. End checks run every cycle in
//   INN1/INN2 on the registered values, so an innings closes 1 cycle after the
//   deciding delivery.
//  INN1 -> INN2 when team1 wickets >= MAX_WICKETS or overs == OVERS.
//   On that edge:
//   - teamSwitch <= 1
//   - target <= {1'b0, team1 runs} + 1 (9-bit; 255 gives 256)
//   - overs/ballsInOver <= 0
//  INN2 -> DONE when any of these hold:
//   - {1'b0, team2 runs} >= target
//   - team2 wickets >= MAX_WICKETS
//   - overs == OVERS
//  INN2 -> DONE edge:
//   - gameOver <= 1
//   - winner: 10 if team2 runs >= target; 11 if team2 runs == target-1; else 01
//   - chase check takes priority if several conditions hold together
//  DONE: terminal. play ignored, all outputs held, until reset.
//  Play pulses are >= 2 cycles apart (debounced button). If play coincides with an
//   innings-closing edge, it is not counted. The transition wins.
//  No play: all outputs hold. teamData changes with no play do not move counters,
//   but end checks still apply.
// STRUCTURE
//  cricket_pkg: state encoding (INN1/INN2/DONE), winner codes, code constants
//   WIDE=13, NOBALL=14, WICKET=15, and field slices RUNS=[11:4], WKTS=[3:0].
//   Shared with the score block.
//  Sub-module ball_counter: legal-ball/over counter with clear and wrap at
//   BALLS_PER_OVER; outputs overs, ballsInOver, inningsBallsDone (overs==OVERS).
//  Top: 3-state FSM, target/winner registers, compare logic.
// TESTING
//  1. Reset, then 6 plays with lfsr_out=3 -> overs=1, ballsInOver=0, teamSwitch=0.
//  2. 4 plays lfsr_out=13/14 interleaved with 2 plays lfsr_out=0 -> ballsInOver=2,
//     overs=0.
//  3. team1Data=12'h0FA (runs 15, wkts 10) -> next cycle teamSwitch=1, target=16,
//     overs=0.
//  4. INN2, team2Data runs 16 wkts 3 -> next cycle gameOver=1, winner=10, state=DONE.
//     Further play changes nothing.
//  5. OVERS=1: 6 legal balls each innings, team1 runs 20, team2 runs 20 -> winner=11.
//     Team2 runs 19 -> winner=01.
//  6. Reset asserted mid-INN2 -> next edge state=INN1, all outputs at reset values.
//     Play with reset held is ignored.

Source files
------------

// File: rtl/cricket_pkg.sv
// Shared match-level definitions: state and winner encodings, delivery codes,
// and accessors for the packed {runs, wickets} score word.
package cricket_pkg;

  typedef enum logic [1:0] {
    ST_INN1 = 2'b00,
    ST_INN2 = 2'b01,
    ST_DONE = 2'b10
  } match_state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_TEAM1 = 2'b01,
    WIN_TEAM2 = 2'b10,
    WIN_TIE   = 2'b11
  } winner_e;

  localparam logic [3:0] CODE_WIDE   = 4'd13;
  localparam logic [3:0] CODE_NOBALL = 4'd14;
  localparam logic [3:0] CODE_WICKET = 4'd15;

  localparam int unsigned RUNS_MSB = 11;
  localparam int unsigned RUNS_LSB = 4;
  localparam int unsigned WKTS_MSB = 3;
  localparam int unsigned WKTS_LSB = 0;

  function automatic logic [7:0] runs_of(input logic [11:0] data);
    return data[RUNS_MSB:RUNS_LSB];
  endfunction

  function automatic logic [3:0] wkts_of(input logic [11:0] data);
    return data[WKTS_MSB:WKTS_LSB];
  endfunction

  // A wicket still uses up a delivery; only wides and no-balls are extras.
  function automatic logic is_legal(input logic [3:0] code);
    return (code == CODE_WICKET) || ((code != CODE_WIDE) && (code != CODE_NOBALL));
  endfunction

endpackage

// File: rtl/innings_controller_ball_counter.sv
// Legal-delivery counter: balls within the over wrap at BALLS_PER_OVER and
// advance the completed-overs count; clear restarts the innings tally.
module ball_counter
  import cricket_pkg::*;
#(
  parameter int unsigned OVERS          = 20,
  parameter int unsigned BALLS_PER_OVER = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       legal_i,
  output logic [4:0] overs_o,
  output logic [2:0] balls_o,
  output logic       innings_balls_done_o
);

  logic [4:0] overs_q, overs_d;
  logic [2:0] balls_q, balls_d;

  always_comb begin
    overs_d = overs_q;
    balls_d = balls_q;
    if (clear_i) begin
      overs_d = '0;
      balls_d = '0;
    end else if (legal_i) begin
      if (balls_q == 3'(BALLS_PER_OVER - 1)) begin
        balls_d = '0;
        overs_d = overs_q + 5'd1;
      end else begin
        balls_d = balls_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overs_q <= '0;
      balls_q <= '0;
    end else begin
      overs_q <= overs_d;
      balls_q <= balls_d;
    end
  end

  assign overs_o              = overs_q;
  assign balls_o              = balls_q;
  assign innings_balls_done_o = (overs_q == 5'(OVERS));

endmodule

// File: rtl/innings_controller.sv
// Match sequencer: counts legal deliveries, closes each innings on wickets or
// overs (or a successful chase), sets the target and resolves the winner.
module innings_controller
  import cricket_pkg::*;
#(
  parameter int unsigned OVERS          = 20,
  parameter int unsigned BALLS_PER_OVER = 6,
  parameter int unsigned MAX_WICKETS    = 10
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        play,
  input  logic [3:0]  lfsr_out,
  input  logic [11:0] team1Data,
  input  logic [11:0] team2Data,
  output logic        teamSwitch,
  output logic        gameOver,
  output logic [4:0]  overs,
  output logic [2:0]  ballsInOver,
  output logic [8:0]  target,
  output logic [1:0]  winner,
  output logic [1:0]  matchState
);

  match_state_e state_q;
  winner_e      winner_q;
  logic         team_switch_q;
  logic         game_over_q;
  logic [8:0]   target_q;

  logic         balls_done;
  logic         close_inn1;
  logic         close_inn2;
  logic         chase_made;
  logic         count_ball;
  logic [8:0]   runs2_ext;
  winner_e      result;

  always_comb begin
    runs2_ext  = {1'b0, runs_of(team2Data)};
    chase_made = (runs2_ext >= target_q);
    close_inn1 = (state_q == ST_INN1) &&
                 ((wkts_of(team1Data) >= 4'(MAX_WICKETS)) || balls_done);
    close_inn2 = (state_q == ST_INN2) &&
                 (chase_made || (wkts_of(team2Data) >= 4'(MAX_WICKETS)) || balls_done);
    // A delivery landing on an innings-closing edge is dropped: the transition wins.
    count_ball = play && is_legal(lfsr_out) && (state_q != ST_DONE) &&
                 !close_inn1 && !close_inn2;
    if (chase_made)
      result = WIN_TEAM2;
    else if (runs2_ext == target_q - 9'd1)
      result = WIN_TIE;
    else
      result = WIN_TEAM1;
  end

  ball_counter #(
    .OVERS         (OVERS),
    .BALLS_PER_OVER(BALLS_PER_OVER)
  ) u_ball_counter (
    .clk_i               (clk_fpga),
    .rst_i               (reset),
    .clear_i             (close_inn1),
    .legal_i             (count_ball),
    .overs_o             (overs),
    .balls_o             (ballsInOver),
    .innings_balls_done_o(balls_done)
  );

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q       <= ST_INN1;
      team_switch_q <= 1'b0;
      game_over_q   <= 1'b0;
      target_q      <= '0;
      winner_q      <= WIN_NONE;
    end else begin
      case (state_q)
        ST_INN1: begin
          if (close_inn1) begin
            state_q       <= ST_INN2;
            team_switch_q <= 1'b1;
            target_q      <= {1'b0, runs_of(team1Data)} + 9'd1;
          end
        end
        ST_INN2: begin
          if (close_inn2) begin
            state_q     <= ST_DONE;
            game_over_q <= 1'b1;
            winner_q    <= result;
          end
        end
        ST_DONE: ;
        default: state_q <= ST_INN1;
      endcase
    end
  end

  assign teamSwitch = team_switch_q;
  assign gameOver   = game_over_q;
  assign target     = target_q;
  assign winner     = winner_q;
  assign matchState = state_q;

endmodule

// File: tb/tb_innings_controller.sv
// Directed bench for innings_controller: default-sized match plus a one-over
// instance for full-match winner resolution.
module tb_innings_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [3:0]  lfsr_out;
  logic [11:0] team1Data, team2Data;
  logic [11:0] team1b, team2b;

  logic        ts0, go0, ts1, go1;
  logic [4:0]  ov0, ov1;
  logic [2:0]  bl0, bl1;
  logic [8:0]  tg0, tg1;
  logic [1:0]  wn0, wn1, st0, st1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  innings_controller dut (
    .clk_fpga(clk), .reset(reset), .play(play), .lfsr_out(lfsr_out),
    .team1Data(team1Data), .team2Data(team2Data),
    .teamSwitch(ts0), .gameOver(go0), .overs(ov0), .ballsInOver(bl0),
    .target(tg0), .winner(wn0), .matchState(st0)
  );

  innings_controller #(.OVERS(1), .BALLS_PER_OVER(6), .MAX_WICKETS(10)) dut_one (
    .clk_fpga(clk), .reset(reset), .play(play), .lfsr_out(lfsr_out),
    .team1Data(team1b), .team2Data(team2b),
    .teamSwitch(ts1), .gameOver(go1), .overs(ov1), .ballsInOver(bl1),
    .target(tg1), .winner(wn1), .matchState(st1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    play  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle pulse followed by one idle cycle; returns at the negedge after the counting edge.
  task automatic deliver(input logic [3:0] code);
    @(negedge clk);
    play     = 1'b1;
    lfsr_out = code;
    @(negedge clk);
    play     = 1'b0;
  endtask

  task automatic match_one_over(input logic [7:0] r1, input logic [7:0] r2,
                                input logic [1:0] exp_win, input logic [8:0] exp_tgt);
    do_reset();
    team1b = {r1, 4'd0};
    team2b = '0;
    for (int i = 0; i < 6; i++) deliver(4'd3);
    @(negedge clk);
    check("m1_switch", ts1, 1);
    check("m1_target", tg1, exp_tgt);
    check("m1_overs_clr", ov1, 0);
    team2b = {r2, 4'd0};
    for (int i = 0; i < 6; i++) deliver(4'd2);
    @(negedge clk);
    check("m1_gameover", go1, 1);
    check("m1_winner", wn1, exp_win);
    check("m1_state", st1, 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; play = 1'b0; lfsr_out = '0;
    team1Data = '0; team2Data = '0; team1b = '0; team2b = '0;

    do_reset();
    @(negedge clk);
    check("rst_state", st0, 0);
    check("rst_switch", ts0, 0);
    check("rst_gameover", go0, 0);
    check("rst_overs", ov0, 0);
    check("rst_balls", bl0, 0);
    check("rst_target", tg0, 0);
    check("rst_winner", wn0, 0);

    for (int i = 0; i < 5; i++) deliver(4'd3);
    check("t1_balls5", bl0, 5);
    deliver(4'd3);
    check("t1_overs", ov0, 1);
    check("t1_balls", bl0, 0);
    check("t1_switch", ts0, 0);

    do_reset();
    deliver(4'd13); deliver(4'd0); deliver(4'd14);
    deliver(4'd13); deliver(4'd0); deliver(4'd14);
    check("t2_balls", bl0, 2);
    check("t2_overs", ov0, 0);
    deliver(4'd15);
    check("t2_wicket_legal", bl0, 3);

    @(negedge clk);
    team1Data = 12'h0F9;
    @(negedge clk);
    check("t3_nine_wkts", ts0, 0);
    team1Data = 12'h0FA;
    @(negedge clk);
    check("t3_switch", ts0, 1);
    check("t3_target", tg0, 16);
    check("t3_overs", ov0, 0);
    check("t3_balls", bl0, 0);
    check("t3_state", st0, 1);

    deliver(4'd1); deliver(4'd4);
    check("t4_inn2_balls", bl0, 2);
    @(negedge clk);
    team2Data = 12'h103;
    play      = 1'b1;
    lfsr_out  = 4'd0;
    @(negedge clk);
    play = 1'b0;
    check("t4_gameover", go0, 1);
    check("t4_winner", wn0, 2);
    check("t4_state", st0, 2);
    check("t4_coincident_drop", bl0, 2);
    for (int i = 0; i < 3; i++) deliver(4'd0);
    check("t4_done_balls", bl0, 2);
    check("t4_done_overs", ov0, 0);
    check("t4_done_winner", wn0, 2);

    do_reset();
    team2Data = '0;
    @(negedge clk);
    team1Data = 12'h0FA;
    @(negedge clk);
    team1Data = '0;
    check("t6_in_inn2", st0, 1);
    deliver(4'd0); deliver(4'd6);
    check("t6_balls", bl0, 2);
    @(negedge clk);
    reset    = 1'b1;
    play     = 1'b1;
    lfsr_out = 4'd0;
    @(negedge clk);
    play = 1'b0;
    check("t6_state", st0, 0);
    check("t6_switch", ts0, 0);
    check("t6_target", tg0, 0);
    check("t6_balls_clr", bl0, 0);
    check("t6_gameover", go0, 0);
    check("t6_winner", wn0, 0);
    @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    play  = 1'b0;
    reset = 1'b0;
    check("t6_play_in_reset", bl0, 0);

    match_one_over(8'd20, 8'd20, 2'b11, 9'd21);
    match_one_over(8'd20, 8'd19, 2'b01, 9'd21);
    match_one_over(8'd255, 8'd255, 2'b11, 9'd256);
    match_one_over(8'd20, 8'd21, 2'b10, 9'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
